// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM encoding
// and default memory geometry.
package lsu_pkg;

  localparam int unsigned MEM_WORDS_DEF = 256;
  localparam int unsigned MEM_AW_DEF    = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    MRG  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_e;

  // Stores only have signed-width codes; unsigned variants exist for loads.
  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    if (store) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction/extension for loads and sub-word merge for stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] rdata_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_data_c_o,
  output logic [31:0] merge_data_c_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = rdata_i[7:0];
    case (byte_off_i)
      2'd1:    byte_c = rdata_i[15:8];
      2'd2:    byte_c = rdata_i[23:16];
      2'd3:    byte_c = rdata_i[31:24];
      default: byte_c = rdata_i[7:0];
    endcase
    half_c = byte_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_B:    load_data_c_o = {{24{byte_c[7]}}, byte_c};
      F3_BU:   load_data_c_o = {24'h0, byte_c};
      F3_H:    load_data_c_o = {{16{half_c[15]}}, half_c};
      F3_HU:   load_data_c_o = {16'h0, half_c};
      default: load_data_c_o = rdata_i;
    endcase

    // Untouched bytes of the read word pass through to the write-back.
    merge_data_c_o = rdata_i;
    if (funct3_i == F3_B) begin
      case (byte_off_i)
        2'd0:    merge_data_c_o[7:0]   = wdata_i[7:0];
        2'd1:    merge_data_c_o[15:8]  = wdata_i[7:0];
        2'd2:    merge_data_c_o[23:16] = wdata_i[7:0];
        default: merge_data_c_o[31:24] = wdata_i[7:0];
      endcase
    end else if (funct3_i == F3_H) begin
      if (byte_off_i[1]) merge_data_c_o[31:16] = wdata_i;
      else               merge_data_c_o[15:0]  = wdata_i;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, read-modify-write for sub-word
// stores, single-cycle completion pulse with error flag.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
  parameter int unsigned MEM_AW    = MEM_AW_DEF
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] Mem_Address,
  output logic [31:0] Mem_WriteData,
  output logic        Mem_Write_EN,
  input  logic [31:0] Mem_Read_Data
);

  localparam int unsigned AW = MEM_AW + 2;

  state_e        state_q, state_d;
  logic          store_q, store_d;
  logic [2:0]    f3_q, f3_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          ready_q, ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;

  logic          misalign_c, range_c, req_err_c;
  logic [31:0]   load_data_c, merge_data_c;

  // Classify the incoming request before it is accepted.
  always_comb begin
    misalign_c = 1'b0;
    if (req_funct3[1:0] == 2'b01)      misalign_c = req_addr[0];
    else if (req_funct3[1:0] == 2'b10) misalign_c = (req_addr[1:0] != 2'b00);
    range_c   = (req_addr[31:AW] != '0) || (req_addr[31:2] >= 30'(MEM_WORDS));
    req_err_c = misalign_c || range_c || !f3_legal(req_store, req_funct3);
  end

  lsu_align u_align (
    .funct3_i       (f3_q),
    .byte_off_i     (addr_q[1:0]),
    .rdata_i        (Mem_Read_Data),
    .wdata_i        (wdata_q),
    .load_data_c_o  (load_data_c),
    .merge_data_c_o (merge_data_c)
  );

  // Outputs are computed for the state being entered so they register cleanly.
  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    mem_we_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d = req_store;
          f3_d    = req_funct3;
          addr_d  = req_addr[AW-1:0];
          wdata_d = req_wdata[15:0];
          if (req_err_c) begin
            state_d    = RESP;
            resp_err_d = 1'b1;
          end else if (req_store && (req_funct3 == F3_W)) begin
            state_d     = WR;
            mem_we_d    = 1'b1;
            mem_wdata_d = req_wdata;
            mem_addr_d  = 32'(req_addr[AW-1:2]);
          end else begin
            state_d    = RD;
            mem_addr_d = 32'(req_addr[AW-1:2]);
          end
        end
      end
      RD: state_d = MRG;
      MRG: begin
        if (store_q) begin
          state_d     = WR;
          mem_we_d    = 1'b1;
          mem_wdata_d = merge_data_c;
          mem_addr_d  = 32'(addr_q[AW-1:2]);
        end else begin
          state_d      = RESP;
          resp_rdata_d = load_data_c;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d      = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign req_ready     = ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_err      = resp_err_q;
  assign resp_rdata    = resp_rdata_q;
  assign Mem_Address   = mem_addr_q;
  assign Mem_WriteData = mem_wdata_q;
  assign Mem_Write_EN  = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with a 1-cycle-latency data memory and a response
// scoreboard.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] Mem_Address;
  logic [31:0] Mem_WriteData;
  logic        Mem_Write_EN;
  logic [31:0] Mem_Read_Data = 32'h0;

  logic [31:0] mem [256] = '{4: 32'h80FF7F01, default: 32'h0};

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t exp_q[$];
  resp_t obs_q[$];

  int checks = 0;
  int passed = 0;

  load_store_unit dut (
    .CLK           (CLK),
    .RST_n         (RST_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_store     (req_store),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .Mem_Address   (Mem_Address),
    .Mem_WriteData (Mem_WriteData),
    .Mem_Write_EN  (Mem_Write_EN),
    .Mem_Read_Data (Mem_Read_Data)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (Mem_Write_EN) mem[Mem_Address[7:0]] <= Mem_WriteData;
    Mem_Read_Data <= mem[Mem_Address[7:0]];
  end

  always @(negedge CLK) begin
    if (resp_valid) obs_q.push_back(resp_t'{rdata: resp_rdata, err: resp_err});
  end

  // Drive one request and record what the DUT does over the following cycles.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int resp_cyc, output int n_wr,
                        output int wr_cyc, output logic [31:0] wr_idx,
                        output logic [31:0] wr_data, output int n_rd);
    resp_cyc = -1; n_wr = 0; wr_cyc = -1; wr_idx = 32'h0; wr_data = 32'h0; n_rd = 0;
    @(negedge CLK);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge CLK);
    #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      if (Mem_Write_EN) begin
        n_wr++; wr_cyc = k; wr_idx = Mem_Address; wr_data = Mem_WriteData;
      end else if (Mem_Address != 32'h0) begin
        n_rd++;
      end
      if (resp_valid) begin
        resp_cyc = k;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'hCAFEF00D;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", req_ready); else passed++;
    checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b exp 0", resp_valid); else passed++;
    checks++; if (resp_err !== 1'b0) $display("FAIL rst_resp_err got %b exp 0", resp_err); else passed++;
    checks++; if (resp_rdata !== 32'h0) $display("FAIL rst_rdata got %h exp 0", resp_rdata); else passed++;
    checks++; if (Mem_Write_EN !== 1'b0) $display("FAIL rst_we got %b exp 0", Mem_Write_EN); else passed++;
    checks++; if (Mem_Address !== 32'h0) $display("FAIL rst_addr got %h exp 0", Mem_Address); else passed++;
    checks++; if (Mem_WriteData !== 32'h0) $display("FAIL rst_wdata got %h exp 0", Mem_WriteData); else passed++;
    req_valid = 1'b0;
    RST_n = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", req_ready); else passed++;
    checks++; if (mem[4] !== 32'h80FF7F01) $display("FAIL rst_ignored_req mem4 got %h exp 80ff7f01", mem[4]); else passed++;
    checks++; if (obs_q.size() != 0) $display("FAIL rst_no_resp got %0d responses exp 0", obs_q.size()); else passed++;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] adrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    int rc, nw, wc, nr;
    logic [31:0] wi, wdat;
    resp_t e, o;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(resp_t'{rdata: exps[i], err: 1'b0});
      run_op(1'b0, f3s[i], adrs[i], 32'h0, rc, nw, wc, wi, wdat, nr);
      checks++; if (rc !== 3) $display("FAIL load%0d_latency got %0d exp 3", i, rc); else passed++;
      checks++; if (nw !== 0) $display("FAIL load%0d_no_write got %0d exp 0", i, nw); else passed++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL load_resp missing exp %h/%b", e.rdata, e.err);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL load_resp got %h/%b exp %h/%b", o.rdata, o.err, e.rdata, e.err);
        else passed++;
      end
    end
  endtask

  task automatic test_errors();
    logic        sts  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  f3s  [4] = '{3'b010, 3'b001, 3'b100, 3'b011};
    logic [31:0] adrs [4] = '{32'h13, 32'h400, 32'h10, 32'h10};
    int rc, nw, wc, nr;
    logic [31:0] wi, wdat;
    resp_t e, o;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(resp_t'{rdata: 32'h0, err: 1'b1});
      run_op(sts[i], f3s[i], adrs[i], 32'h5A5A5A5A, rc, nw, wc, wi, wdat, nr);
      checks++; if (rc !== 1) $display("FAIL err%0d_latency got %0d exp 1", i, rc); else passed++;
      checks++; if (nw !== 0) $display("FAIL err%0d_no_write got %0d exp 0", i, nw); else passed++;
      checks++; if (nr !== 0) $display("FAIL err%0d_no_read got %0d exp 0", i, nr); else passed++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL err_resp missing exp %h/%b", e.rdata, e.err);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL err_resp got %h/%b exp %h/%b", o.rdata, o.err, e.rdata, e.err);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic rdy [11];
    int   resp_k [$];
    int   nw = 0;
    resp_t e, o;
    exp_q.push_back(resp_t'{rdata: 32'h00000080, err: 1'b0});
    exp_q.push_back(resp_t'{rdata: 32'h00007F01, err: 1'b0});
    @(negedge CLK);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b100; req_addr = 32'h13;
    @(posedge CLK);
    #1;
    req_funct3 = 3'b101; req_addr = 32'h10;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      rdy[k] = req_ready;
      if (resp_valid) resp_k.push_back(k);
      if (Mem_Write_EN) nw++;
      if (k == 5) req_valid = 1'b0;
    end
    for (int k = 1; k <= 3; k++) begin
      checks++; if (rdy[k] !== 1'b0) $display("FAIL b2b_ready_c%0d got %b exp 0", k, rdy[k]); else passed++;
    end
    checks++; if (rdy[4] !== 1'b1) $display("FAIL b2b_ready_c4 got %b exp 1", rdy[4]); else passed++;
    checks++; if (rdy[5] !== 1'b0) $display("FAIL b2b_ready_c5 got %b exp 0", rdy[5]); else passed++;
    checks++; if (resp_k.size() != 2) $display("FAIL b2b_resp_count got %0d exp 2", resp_k.size()); else passed++;
    if (resp_k.size() == 2) begin
      checks++; if (resp_k[0] != 3) $display("FAIL b2b_first_resp got %0d exp 3", resp_k[0]); else passed++;
      checks++; if (resp_k[1] != 7) $display("FAIL b2b_second_resp got %0d exp 7", resp_k[1]); else passed++;
    end
    checks++; if (nw != 0) $display("FAIL b2b_no_write got %0d exp 0", nw); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL b2b_resp missing exp %h/%b", e.rdata, e.err);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL b2b_resp got %h/%b exp %h/%b", o.rdata, o.err, e.rdata, e.err);
        else passed++;
      end
    end
  endtask

  task automatic test_sb();
    int rc, nw, wc, nr;
    logic [31:0] wi, wdat;
    resp_t e, o;
    exp_q.push_back(resp_t'{rdata: 32'h0, err: 1'b0});
    run_op(1'b1, 3'b000, 32'h11, 32'h123456AB, rc, nw, wc, wi, wdat, nr);
    checks++; if (rc !== 4) $display("FAIL sb_latency got %0d exp 4", rc); else passed++;
    checks++; if (nw !== 1) $display("FAIL sb_write_count got %0d exp 1", nw); else passed++;
    checks++; if (wc !== 3) $display("FAIL sb_write_cycle got %0d exp 3", wc); else passed++;
    checks++; if (wi !== 32'h4) $display("FAIL sb_write_index got %h exp 4", wi); else passed++;
    checks++; if (wdat !== 32'h80FFAB01) $display("FAIL sb_write_data got %h exp 80ffab01", wdat); else passed++;
    checks++; if (nr !== 1) $display("FAIL sb_read_cycles got %0d exp 1", nr); else passed++;
    checks++; if (mem[4] !== 32'h80FFAB01) $display("FAIL sb_mem4 got %h exp 80ffab01", mem[4]); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL sb_resp missing exp %h/%b", e.rdata, e.err);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL sb_resp got %h/%b exp %h/%b", o.rdata, o.err, e.rdata, e.err);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] snap;
    int nw = 0;
    int nresp = 0;
    snap = mem[4];
    obs_q.delete();
    @(negedge CLK);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h11; req_wdata = 32'h00000055;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    repeat (2) @(negedge CLK);
    RST_n = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      if (Mem_Write_EN) nw++;
      if (resp_valid) nresp++;
    end
    RST_n = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      if (Mem_Write_EN) nw++;
      if (resp_valid) nresp++;
    end
    checks++; if (nw != 0) $display("FAIL abort_no_write got %0d exp 0", nw); else passed++;
    checks++; if (nresp != 0) $display("FAIL abort_no_resp got %0d exp 0", nresp); else passed++;
    checks++; if (mem[4] !== snap) $display("FAIL abort_mem4 got %h exp %h", mem[4], snap); else passed++;
    checks++; if (req_ready !== 1'b1) $display("FAIL abort_ready got %b exp 1", req_ready); else passed++;
    checks++; if (obs_q.size() != 0) $display("FAIL abort_scoreboard got %0d exp 0", obs_q.size()); else passed++;
  endtask

  task automatic test_sw();
    int rc, nw, wc, nr;
    logic [31:0] wi, wdat;
    resp_t e, o;
    exp_q.push_back(resp_t'{rdata: 32'h0, err: 1'b0});
    run_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rc, nw, wc, wi, wdat, nr);
    checks++; if (rc !== 2) $display("FAIL sw_latency got %0d exp 2", rc); else passed++;
    checks++; if (wc !== 1) $display("FAIL sw_write_cycle got %0d exp 1", wc); else passed++;
    checks++; if (nw !== 1) $display("FAIL sw_write_count got %0d exp 1", nw); else passed++;
    checks++; if (nr !== 0) $display("FAIL sw_no_read got %0d exp 0", nr); else passed++;
    checks++; if (wi !== 32'h4) $display("FAIL sw_write_index got %h exp 4", wi); else passed++;
    checks++; if (wdat !== 32'hDEADBEEF) $display("FAIL sw_write_data got %h exp deadbeef", wdat); else passed++;
    exp_q.push_back(resp_t'{rdata: 32'hDEADBEEF, err: 1'b0});
    run_op(1'b0, 3'b010, 32'h10, 32'h0, rc, nw, wc, wi, wdat, nr);
    checks++; if (rc !== 3) $display("FAIL lw_latency got %0d exp 3", rc); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL sw_resp missing exp %h/%b", e.rdata, e.err);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL sw_resp got %h/%b exp %h/%b", o.rdata, o.err, e.rdata, e.err);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_errors();
    test_back_to_back();
    test_sb();
    test_reset_abort();
    test_sw();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d of %0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be as follows:
- MEM_WORDS, default 256: data-memory depth in 32-bit words.
- MEM_AW, default 8: word-index width, equal to log2(MEM_WORDS).

REQ-002 The block SHALL have one clock; reset is asynchronous and active-low. Ports, clock and reset first:
- CLK  in  1  rising-edge clock.
- RST_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core presents a memory operation.
- req_ready  out  1  unit can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data.
- resp_err  out  1  misaligned, out-of-range or illegal funct3.
- Mem_Address  out  32  word index into data memory.
- Mem_WriteData  out  32  full word to write.
- Mem_Write_EN  out  1  memory write strobe.
- Mem_Read_Data  in  32  memory data, valid one cycle after the address is presented.

Function
REQ-003 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_ready SHALL equal (state==IDLE).
REQ-004 The accepted opcode, address and data SHALL be registered; request inputs SHALL then be ignored until the unit returns to IDLE.
REQ-005 FSM states SHALL be IDLE, RD, MRG, WR and RESP.
REQ-006 FSM transitions from IDLE on acceptance:
- error -> RESP.
- SW -> WR.
- all other operations -> RD.
REQ-007 Remaining FSM transitions:
- RD -> MRG.
- MRG -> RESP for loads; MRG -> WR for SB and SH.
- WR -> RESP.
- RESP -> IDLE.
REQ-008 An error SHALL be any of: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; addr[31:MEM_AW+2]!=0; funct3 not listed in REQ-002.
REQ-009 Mem_Address SHALL equal the zero-extended registered addr[MEM_AW+1:2] in RD and WR, and 0 otherwise.
REQ-010 Memory outputs SHALL have no combinational path from req_* inputs.
REQ-011 Mem_Write_EN SHALL be 1 only in WR, for exactly one cycle per store.
REQ-012 Mem_Write_EN SHALL never assert for loads or error requests.
REQ-013 In MRG, the lane SHALL be selected by addr[1:0] for bytes and addr[1] for halfwords.
REQ-014 In MRG, loads SHALL sign-extend (LB/LH) or zero-extend (LBU/LHU) the selected lane into a register.
REQ-015 In MRG, SB/SH SHALL merge req_wdata[7:0] or [15:0] into the read word, leaving other bytes unchanged; the result is registered for WR.
REQ-016 SW SHALL write req_wdata unchanged without a preceding read.
REQ-017 Latency from the acceptance edge to resp_valid SHALL be:
- error: 1 cycle.
- SW: 2 cycles.
- LB/LH/LW/LBU/LHU: 3 cycles.
- SB/SH: 4 cycles.
REQ-018 resp_valid SHALL be high for exactly one cycle, in RESP.
REQ-019 resp_rdata SHALL hold load data during RESP and be 0 for stores and errors.
REQ-020 resp_err SHALL be high only in RESP, and only for an error request.
REQ-021 There is no response back-pressure; the core SHALL be ready for resp_valid.

Reset
REQ-022 While RST_n=0, the state SHALL be IDLE, all registers 0, and all outputs 0 except req_ready, which SHALL be 1.
REQ-023 Requests presented while RST_n=0 SHALL be ignored.
REQ-024 Reset asserted in any state SHALL abort the operation immediately.
REQ-025 A pending SB/SH merge aborted by reset SHALL never be written, and no resp_valid SHALL be produced for an aborted request.

Structure
REQ-026 Package lsu_pkg SHALL hold the funct3 encodings, the FSM state encoding, and MEM_WORDS/MEM_AW defaults.
REQ-027 One combinational sub-module, lsu_align, SHALL perform lane extraction/extension and store merging; all state SHALL reside in load_store_unit.

Verification
REQ-028 The bench SHALL use a memory model with 1-cycle read latency, preloaded with word 4 = 0x80FF7F01, and SHALL cover:
- LB 0x13 -> resp_rdata 0xFFFFFF80 at cycle 3. LBU 0x13 -> 0x00000080. LH 0x12 -> 0xFFFF80FF. LHU 0x10 -> 0x00007F01.
- SB 0x11, wdata 0x123456AB -> single Mem_Write_EN at cycle 3, index 4, data 0x80FFAB01; resp_valid at cycle 4.
- SW 0x10, wdata 0xDEADBEEF -> write at cycle 1 with no read cycle; resp_valid at cycle 2; a following LW 0x10 -> 0xDEADBEEF.
- LW 0x13, and SH 0x400 -> resp_err=1 at cycle 1, no Mem_Write_EN, resp_rdata 0.
- RST_n pulsed low during MRG of SB 0x11 -> no write, no resp_valid; word 4 unchanged; req_ready=1 after release.
- Back-to-back requests with req_valid held high -> req_ready low from cycle 1 until RESP+1; the second request is accepted only in IDLE.
